// File: rtl/clb_cfg_pkg.sv
// Shared configuration helpers for the CLB wide-function mux slices:
// config width, node enable bit placement and a clog2 for counter sizing.
package clb_cfg_pkg;

  function automatic int clog2_int(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic int cfg_width(input int num_luts);
    return 2 * num_luts - 1;
  endfunction

  // Node enables are packed level 1 first, node index ascending within a level.
  function automatic int node_cfg_idx(input int level, input int j, input int num_luts);
    int offset;
    offset = 0;
    for (int l = 1; l < level; l++) begin
      offset += num_luts >> l;
    end
    return offset + j;
  endfunction

endpackage

// File: rtl/mux_f_node.sv
// One wide-function tree node: passes the lower input unless enabled and
// selected, in which case the upper half's result is forwarded.
module mux_f_node (
  input  logic en,
  input  logic sel,
  input  logic din_lo,
  input  logic din_hi,
  output logic dout
);

  assign dout = (en && sel) ? din_hi : din_lo;

endmodule

// File: rtl/mux_f_tree.sv
// Parametrised F-mux tree slice: per-node enabled binary mux tree over the
// LUT outputs, optional per-output registers, serial scan-chain configuration.
module mux_f_tree
  import clb_cfg_pkg::*;
#(
  parameter int MUX_LEVELS = 3,
  parameter int NUM_LUTS   = 8
) (
  input  logic                  cclk,
  input  logic                  rst_n,
  input  logic [NUM_LUTS-1:0]   luts_out,
  input  logic [MUX_LEVELS-1:0] addr,
  input  logic                  ce,
  output logic [NUM_LUTS-1:0]   out,
  input  logic                  cen,
  input  logic                  config_in,
  output logic                  config_out,
  output logic                  cfg_valid
);

  localparam int CFG_W = cfg_width(NUM_LUTS);
  localparam int CNT_W = clog2_int(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

  logic [CFG_W-1:0]    cfg;
  logic [CFG_W-1:0]    eff_cfg;
  logic [CNT_W-1:0]    count;
  logic [NUM_LUTS-1:0] q;
  logic [NUM_LUTS-1:0] comb_res;
  logic [NUM_LUTS-1:0] reg_en;

  // Scan chain and load counter; the counter saturates so late shifts keep cfg_valid high.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg   <= '0;
      count <= '0;
    end else if (cen) begin
      cfg <= {cfg[CFG_W-2:0], config_in};
      if (count != CNT_FULL) begin
        count <= count + 1'b1;
      end
    end
  end

  assign cfg_valid  = (count == CNT_FULL);
  assign config_out = cfg[CFG_W-1];
  assign eff_cfg    = cfg_valid ? cfg : '0;
  assign reg_en     = eff_cfg[CFG_W-1:NUM_LUTS-1];

  // Each level keeps its own vector; only positions on a node base change.
  for (genvar l = 1; l <= MUX_LEVELS; l++) begin : g_level
    logic [NUM_LUTS-1:0] prev;
    logic [NUM_LUTS-1:0] cur;

    if (l == 1) begin : g_first
      assign prev = luts_out;
    end else begin : g_next
      assign prev = g_level[l-1].cur;
    end

    for (genvar k = 0; k < NUM_LUTS; k++) begin : g_pos
      if ((k % (1 << l)) == 0) begin : g_node
        mux_f_node u_node (
          .en     (eff_cfg[node_cfg_idx(l, k >> l, NUM_LUTS)]),
          .sel    (addr[l-1]),
          .din_lo (prev[k]),
          .din_hi (prev[k + (1 << (l-1))]),
          .dout   (cur[k])
        );
      end else begin : g_pass
        assign cur[k] = prev[k];
      end
    end
  end

  assign comb_res = g_level[MUX_LEVELS].cur;

  // Output registers sample the tree only outside configuration shifts.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!cen && ce) begin
      q <= comb_res;
    end
  end

  assign out = (reg_en & q) | (~reg_en & comb_res);

endmodule
